// File: rtl/plru_victim_select_pkg.sv
// Shared constants and tree-indexing helper for the pseudo-LRU replacement unit.
package plru_victim_select_pkg;

    localparam int PLRU_NUMWAYS_DEF  = 4;
    localparam int PLRU_SETLEN_DEF   = 9;
    localparam int PLRU_NUMLINES_DEF = 128;

    // Bit position of tree node 'blk' on level 'level' (root is level 0).
    function automatic int tree_node_idx(input int numways, input int level, input int blk);
        return numways - 1 - (1 << level) - blk;
    endfunction

endpackage

// File: rtl/plru_victim_select_if.sv
// Access-side bus between the cache controller FSM and the PLRU replacement unit.
interface plru_victim_select_if
    import plru_victim_select_pkg::*;
#(
    parameter int NUMWAYS = PLRU_NUMWAYS_DEF,
    parameter int SETLEN  = PLRU_SETLEN_DEF
);
    logic               CacheEn;
    logic [NUMWAYS-1:0] HitWay;
    logic [NUMWAYS-1:0] ValidWay;
    logic [SETLEN-1:0]  CacheSet;
    logic [SETLEN-1:0]  PAdr;
    logic               LRUWriteEn;
    logic               SetValid;
    logic [NUMWAYS-1:0] VictimWay;

    modport master (
        output CacheEn, HitWay, ValidWay, CacheSet, PAdr, LRUWriteEn, SetValid,
        input  VictimWay
    );

    modport slave (
        input  CacheEn, HitWay, ValidWay, CacheSet, PAdr, LRUWriteEn, SetValid,
        output VictimWay
    );
endinterface

// File: rtl/plru_victim_select.sv
// Tree pseudo-LRU state per set: updates on hit/fill and selects the victim way on a miss.
module plru_victim_select
    import plru_victim_select_pkg::*;
#(
    parameter int NUMWAYS  = PLRU_NUMWAYS_DEF,
    parameter int SETLEN   = PLRU_SETLEN_DEF,
    parameter int NUMLINES = PLRU_NUMLINES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    plru_victim_select_if.slave  lru_bus
);

    localparam int LOGNUMWAYS = $clog2(NUMWAYS);
    localparam int TREEW      = NUMWAYS - 1;
    localparam int IDXW       = (NUMLINES > 1) ? $clog2(NUMLINES) : 1;

    logic [TREEW-1:0]      r_mem [NUMLINES];
    logic [TREEW-1:0]      r_curr_lru;
    logic [TREEW-1:0]      w_next_lru;
    logic [LOGNUMWAYS-1:0] w_hit_idx;
    logic [LOGNUMWAYS-1:0] w_victim_idx;
    logic [LOGNUMWAYS-1:0] w_upd_idx;
    logic [LOGNUMWAYS-1:0] w_walk_idx;
    logic [NUMWAYS-1:0]    w_low_invalid;
    logic [NUMWAYS-1:0]    w_walk_way;
    logic [NUMWAYS-1:0]    w_victim_way;
    logic [IDXW-1:0]       w_wr_idx;
    logic [IDXW-1:0]       w_rd_idx;
    logic                  w_bypass;

    assign w_wr_idx = lru_bus.PAdr[IDXW-1:0];
    assign w_rd_idx = lru_bus.CacheSet[IDXW-1:0];
    assign w_bypass = lru_bus.LRUWriteEn && (lru_bus.PAdr == lru_bus.CacheSet);

    // One-hot to binary by OR-ing indices; an all-zero HitWay therefore maps to way 0.
    always_comb begin
        w_hit_idx    = '0;
        w_victim_idx = '0;
        for (int i = 0; i < NUMWAYS; i++) begin
            if (lru_bus.HitWay[i]) w_hit_idx    = w_hit_idx    | LOGNUMWAYS'(i);
            if (w_victim_way[i])   w_victim_idx = w_victim_idx | LOGNUMWAYS'(i);
        end
    end

    assign w_upd_idx = lru_bus.SetValid ? w_victim_idx : w_hit_idx;

    // Nodes on the accessed way's path point away from it; all others keep their value.
    for (genvar gi = 0; gi < LOGNUMWAYS; gi++) begin : g_level
        for (genvar gj = 0; gj < (1 << gi); gj++) begin : g_node
            localparam int NODE = tree_node_idx(NUMWAYS, gi, gj);
            assign w_next_lru[NODE] = ((int'(w_upd_idx) >> (LOGNUMWAYS - gi)) == gj)
                                      ? ~w_upd_idx[LOGNUMWAYS-1-gi]
                                      : r_curr_lru[NODE];
        end
    end

    // Root-to-leaf walk; the accumulated path prefix selects the node on the next level.
    always_comb begin : c_walk
        logic [TREEW-1:0] v_shift;
        v_shift    = '0;
        w_walk_idx = '0;
        for (int d = 0; d < LOGNUMWAYS; d++) begin
            v_shift    = r_curr_lru >> (NUMWAYS - 1 - (1 << d) - int'(w_walk_idx));
            w_walk_idx = (w_walk_idx << 1) | LOGNUMWAYS'(v_shift[0]);
        end
    end

    assign w_walk_way    = NUMWAYS'(1) << w_walk_idx;
    assign w_low_invalid = ~lru_bus.ValidWay & (lru_bus.ValidWay + NUMWAYS'(1));
    assign w_victim_way  = (&lru_bus.ValidWay) ? w_walk_way : w_low_invalid;
    assign lru_bus.VictimWay = w_victim_way;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUMLINES; i++) begin
                r_mem[i] <= '0;
            end
            r_curr_lru <= '0;
        end else if (lru_bus.CacheEn) begin
            if (lru_bus.LRUWriteEn) begin
                r_mem[w_wr_idx] <= w_next_lru;
            end
            r_curr_lru <= w_bypass ? w_next_lru : r_mem[w_rd_idx];
        end
    end

endmodule

// File: tb/tb_plru_victim_select.sv
// Directed checks of the 4-way PLRU unit: victim choice, tree update, bypass, enable and reset.
module tb_plru_victim_select;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    plru_victim_select_if #(.NUMWAYS(4), .SETLEN(9)) lru_bus ();

    plru_victim_select #(.NUMWAYS(4), .SETLEN(9), .NUMLINES(128)) dut (
        .clk     (clk),
        .reset   (reset),
        .lru_bus (lru_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset                = 1'b0;
        lru_bus.CacheEn      = 1'b1;
        lru_bus.HitWay       = 4'b0000;
        lru_bus.ValidWay     = 4'b0000;
        lru_bus.CacheSet     = 9'd5;
        lru_bus.PAdr         = 9'd5;
        lru_bus.LRUWriteEn   = 1'b0;
        lru_bus.SetValid     = 1'b0;
        @(negedge clk);

        // Reset state and lowest-invalid selection
        chk("rst_curr", 8'(dut.r_curr_lru), 8'h0);
        chk("rst_v0000", 8'(lru_bus.VictimWay), 8'h1);
        lru_bus.ValidWay = 4'b1011; #1;
        chk("rst_v1011", 8'(lru_bus.VictimWay), 8'h4);
        lru_bus.ValidWay = 4'b1111; #1;
        chk("rst_v1111", 8'(lru_bus.VictimWay), 8'h1);

        @(negedge clk);
        reset = 1'b1;
        tick();

        // Hit way 0 -> 110, victim way 2
        lru_bus.HitWay = 4'b0001; lru_bus.LRUWriteEn = 1'b1;
        tick();
        lru_bus.LRUWriteEn = 1'b0;
        chk("hit0_curr", 8'(dut.r_curr_lru), 8'h6);
        chk("hit0_vict", 8'(lru_bus.VictimWay), 8'h4);

        // Hit way 2 -> 011, victim way 1
        lru_bus.HitWay = 4'b0100; lru_bus.LRUWriteEn = 1'b1;
        tick();
        lru_bus.LRUWriteEn = 1'b0;
        chk("hit2_curr", 8'(dut.r_curr_lru), 8'h3);
        chk("hit2_vict", 8'(lru_bus.VictimWay), 8'h2);

        lru_bus.ValidWay = 4'b1101; #1;
        chk("partial_inv", 8'(lru_bus.VictimWay), 8'h2);
        lru_bus.ValidWay = 4'b1111; #1;

        // Four back-to-back fills: victims 1,3,0,2
        lru_bus.SetValid = 1'b1; lru_bus.LRUWriteEn = 1'b1;
        chk("fill0_vict", 8'(lru_bus.VictimWay), 8'h2);
        tick();
        chk("fill1_vict", 8'(lru_bus.VictimWay), 8'h8);
        tick();
        chk("fill2_vict", 8'(lru_bus.VictimWay), 8'h1);
        tick();
        chk("fill3_vict", 8'(lru_bus.VictimWay), 8'h4);
        tick();
        lru_bus.LRUWriteEn = 1'b0; lru_bus.SetValid = 1'b0;
        chk("fill_curr", 8'(dut.r_curr_lru), 8'h3);

        // Write set 6 while reading set 5; next bits derive from set 5's CurrLRU
        lru_bus.PAdr = 9'd6; lru_bus.HitWay = 4'b1000; lru_bus.LRUWriteEn = 1'b1;
        tick();
        lru_bus.LRUWriteEn = 1'b0;
        chk("set6_curr5", 8'(dut.r_curr_lru), 8'h3);
        chk("set6_mem", 8'(dut.r_mem[6]), 8'h2);
        lru_bus.CacheSet = 9'd6;
        tick();
        chk("set6_read", 8'(dut.r_curr_lru), 8'h2);
        chk("set6_vict", 8'(lru_bus.VictimWay), 8'h2);

        // CacheEn low freezes memory and CurrLRU
        lru_bus.CacheEn = 1'b0; lru_bus.HitWay = 4'b0001; lru_bus.LRUWriteEn = 1'b1;
        tick();
        chk("frz_curr", 8'(dut.r_curr_lru), 8'h2);
        chk("frz_mem", 8'(dut.r_mem[6]), 8'h2);
        lru_bus.ValidWay = 4'b0111; #1;
        chk("frz_inv", 8'(lru_bus.VictimWay), 8'h8);
        lru_bus.ValidWay = 4'b1111;
        lru_bus.CacheEn = 1'b1; lru_bus.LRUWriteEn = 1'b0; lru_bus.CacheSet = 9'd5; lru_bus.PAdr = 9'd5;
        tick();
        chk("frz_set5", 8'(dut.r_curr_lru), 8'h3);

        // Asynchronous reset in the middle of a write cycle
        lru_bus.HitWay = 4'b0010; lru_bus.LRUWriteEn = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("arst_curr", 8'(dut.r_curr_lru), 8'h0);
        chk("arst_mem5", 8'(dut.r_mem[5]), 8'h0);
        chk("arst_mem6", 8'(dut.r_mem[6]), 8'h0);
        chk("arst_vict", 8'(lru_bus.VictimWay), 8'h1);
        @(negedge clk);
        reset = 1'b1; lru_bus.LRUWriteEn = 1'b0;
        tick();
        chk("post_rst", 8'(dut.r_curr_lru), 8'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
